// File: rtl/calc_pkg.sv
// Shared types and constants for the result-to-UART decimal printer.
// Optional CR/LF trailer is enabled by defining RESULT_TX_EOL_EN.
package calc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SEND,
    S_GAP
  } tx_state_t;

  typedef enum logic [1:0] {
    K_MINUS,
    K_DIGIT,
    K_CR,
    K_LF
  } byte_kind_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  function automatic logic [3:0] dabble_adj(
    input logic [3:0] d
  );
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Iterative double-dabble converter: one input bit per cycle.
// done is high during the final shift; bcd is final the cycle after.
module bin2bcd
  import calc_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                  hwclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]        r_sh;
  logic [4*DIGITS-1:0]     r_bcd;
  logic [CW-1:0]           r_cnt;
  logic                    r_run;

  logic [4*DIGITS-1:0]     w_adj;
  logic [4*DIGITS+WIDTH-1:0] w_nxt;

  always_comb begin
    w_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_adj[4*i +: 4] = dabble_adj(r_bcd[4*i +: 4]);
    end
  end

  assign w_nxt = {w_adj[4*DIGITS-2:0], r_sh, 1'b0};

  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_sh  <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_sh  <= bin;
      r_bcd <= '0;
      r_cnt <= CW'(WIDTH);
      r_run <= 1'b1;
    end else if (r_run) begin
      r_bcd <= w_nxt[WIDTH +: 4*DIGITS];
      r_sh  <= w_nxt[WIDTH-1:0];
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_run <= 1'b0;
      end
    end
  end

  assign done = r_run && (r_cnt == CW'(1));
  assign bcd  = r_bcd;

endmodule

// File: rtl/result_uart_tx.sv
// Prints a signed result as ASCII decimal over a byte-wide UART strobe.
// Define RESULT_TX_EOL_EN to append CR LF after the last digit.
module result_uart_tx
  import calc_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic             hwclk,
  input  logic             reset,
  input  logic             result_valid,
  input  logic [WIDTH-1:0] result,
  input  logic             sign,
  input  logic             txready,
  output logic [7:0]       txdata,
  output logic             txclk,
  output logic             busy
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  tx_state_t   r_state;
  byte_kind_t  r_kind;
  logic [WIDTH-1:0] r_mag;
  logic        r_sign;
  logic [IW-1:0] r_dig;
  logic        r_started;
  logic        r_last;
  logic [7:0]  r_txdata;
  logic        r_txclk;
  logic        r_busy;

  logic        w_start;
  logic        w_done;
  logic [4*DIGITS-1:0] w_bcd;
  logic [IW-1:0] w_lead;
  logic [IW-1:0] w_idx;
  logic [3:0]  w_dval;
  logic [7:0]  w_byte;
  logic        w_final;

  assign w_start = (r_state == S_IDLE) && result_valid;

  bin2bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .hwclk (hwclk),
    .reset (reset),
    .start (w_start),
    .bin   (result),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // Highest nonzero digit; digit 0 when the value is zero.
  always_comb begin
    w_lead = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_bcd[4*i +: 4] != 4'd0) begin
        w_lead = IW'(i);
      end
    end
  end

  assign w_idx = r_started ? r_dig : w_lead;

  always_comb begin
    w_dval = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == w_idx) begin
        w_dval = w_bcd[4*i +: 4];
      end
    end
  end

  always_comb begin
    w_byte = ASCII_ZERO;
    unique case (r_kind)
      K_MINUS: w_byte = ASCII_MINUS;
      K_DIGIT: w_byte = ASCII_ZERO + {4'h0, w_dval};
`ifdef RESULT_TX_EOL_EN
      K_CR:    w_byte = ASCII_CR;
      K_LF:    w_byte = ASCII_LF;
`endif
      default: w_byte = ASCII_ZERO;
    endcase
  end

`ifdef RESULT_TX_EOL_EN
  assign w_final = (r_kind == K_LF);
`else
  assign w_final = (r_kind == K_DIGIT) && (w_idx == '0);
`endif

  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_kind    <= K_DIGIT;
      r_mag     <= '0;
      r_sign    <= 1'b0;
      r_dig     <= '0;
      r_started <= 1'b0;
      r_last    <= 1'b0;
      r_txdata  <= 8'h00;
      r_txclk   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (result_valid) begin
            r_mag   <= result;
            r_sign  <= sign;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          if (w_done) begin
            r_kind    <= (r_sign && (r_mag != '0)) ? K_MINUS : K_DIGIT;
            r_started <= 1'b0;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (txready) begin
            r_txdata <= w_byte;
            r_txclk  <= 1'b1;
            r_last   <= w_final;
            r_state  <= S_GAP;
            unique case (r_kind)
              K_MINUS: r_kind <= K_DIGIT;
              K_DIGIT: begin
                if (w_idx != '0) begin
                  r_dig     <= w_idx - IW'(1);
                  r_started <= 1'b1;
                end
`ifdef RESULT_TX_EOL_EN
                else begin
                  r_kind <= K_CR;
                end
`endif
              end
`ifdef RESULT_TX_EOL_EN
              K_CR:    r_kind <= K_LF;
`endif
              default: ;
            endcase
          end
        end
        S_GAP: begin
          r_txclk <= 1'b0;
          if (r_last) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_SEND;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign txdata = r_txdata;
  assign txclk  = r_txclk;
  assign busy   = r_busy;

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench for result_uart_tx: decimal-string reference model,
// exact strobe timing on directed cases, random results and txready.
module tb_result_uart_tx;

  localparam int WIDTH  = 9;
  localparam int DIGITS = 3;

  logic             hwclk = 1'b0;
  logic             reset = 1'b1;
  logic             result_valid = 1'b0;
  logic [WIDTH-1:0] result = '0;
  logic             sign = 1'b0;
  logic             txready = 1'b1;
  logic [7:0]       txdata;
  logic             txclk;
  logic             busy;

  result_uart_tx #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) dut (
    .hwclk        (hwclk),
    .reset        (reset),
    .result_valid (result_valid),
    .result       (result),
    .sign         (sign),
    .txready      (txready),
    .txdata       (txdata),
    .txclk        (txclk),
    .busy         (busy)
  );

  always #5 hwclk = ~hwclk;

  typedef struct {
    logic [7:0] b;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_tx = -1;
  int   last_exp = -1;
  bit   rnd_on = 1'b0;

  always @(posedge hwclk) cyc <= cyc + 1;

  always @(posedge hwclk)
    if (rnd_on) #2 txready = ($urandom_range(0, 3) != 0);

  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               n, act, act, exp, exp, cyc);
    end
  endfunction

  // Expected bytes from the decimal text of the value.
  function automatic void model(input int v, input bit s, input int base,
                                input int stall, input bit timed);
    logic [7:0] b[$];
    int d[$];
    int t = v;
    exp_t e;
    if (s && v != 0) b.push_back(8'h2D);
    do begin
      d.push_front(t % 10);
      t = t / 10;
    end while (t > 0);
    foreach (d[i]) b.push_back(8'(8'h30 + d[i]));
`ifdef RESULT_TX_EOL_EN
    b.push_back(8'h0D);
    b.push_back(8'h0A);
`endif
    foreach (b[k]) begin
      e.b = b[k];
      e.cyc = timed ? base + WIDTH + 2 + 2 * k + ((k >= 1) ? stall : 0) : -1;
      q.push_back(e);
      last_exp = e.cyc;
    end
  endfunction

  always @(negedge hwclk) begin
    if (txclk) begin
      exp_t e;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_txclk: data 0x%0h at cycle %0d, none expected",
                 txdata, cyc);
      end else begin
        e = q.pop_front();
        chk("txdata", txdata, e.b);
        if (e.cyc >= 0) chk("txclk_cycle", cyc, e.cyc);
      end
      last_tx = cyc;
    end
  end

  task automatic issue(input int v, input bit s, input bit timed,
                       input int stall, output int n);
    result = WIDTH'(v);
    sign = s;
    result_valid = 1'b1;
    n = cyc;
    model(v, s, n, stall, timed);
    @(posedge hwclk); #1;
    result_valid = 1'b0;
    result = WIDTH'($urandom);
    sign = 1'($urandom);
    chk("busy_after_valid", busy, 1);
  endtask

  task automatic wait_idle(input bit timed);
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge hwclk); #1;
      if (!busy) break;
    end
    if (k == 400) chk("busy_timeout", 1, 0);
    else if (timed) chk("busy_fall_cycle", cyc, last_tx + 1);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge hwclk); #1;
    end
  endtask

  initial begin
    int n;
    fork
      begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge hwclk);
    #1;
    chk("reset_txdata", txdata, 8'h00);
    chk("reset_txclk", txclk, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    @(posedge hwclk); #1;

    issue(123, 0, 1, 0, n); wait_idle(1);
    issue(45, 1, 1, 0, n);  wait_idle(1);
    issue(0, 1, 1, 0, n);   wait_idle(1);
    issue(511, 0, 1, 0, n); wait_idle(1);
    issue(7, 0, 1, 0, n);   wait_idle(1);

    // Stall before the second byte, with an ignored result in the stall.
    issue(123, 0, 1, 5, n);
    wait_until(n + 11);
    txready = 1'b0;
    result = 9;
    sign = 1'b0;
    result_valid = 1'b1;
    @(posedge hwclk); #1;
    result_valid = 1'b0;
    wait_until(n + 17);
    txready = 1'b1;
    wait_idle(1);

    // Reset right after the first strobe aborts the transfer.
    issue(123, 0, 1, 0, n);
    wait_until(n + 12);
    reset = 1'b1;
    q.delete();
    @(posedge hwclk); #1;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_txclk", txclk, 0);
    chk("abort_txdata", txdata, 8'h00);
    repeat (30) @(posedge hwclk);
    #1;
    chk("abort_still_idle", busy, 0);

    // Reset wins over a simultaneous result_valid.
    reset = 1'b1;
    result = 55;
    result_valid = 1'b1;
    @(posedge hwclk); #1;
    reset = 1'b0;
    result_valid = 1'b0;
    chk("reset_priority_busy", busy, 0);
    repeat (20) @(posedge hwclk);
    #1;

    rnd_on = 1'b1;
    for (int i = 0; i < 25; i++) begin
      issue(int'($urandom_range(0, 511)), 1'($urandom), 0, 0, n);
      wait_idle(0);
    end
    rnd_on = 1'b0;
    #3;
    txready = 1'b1;
    repeat (5) @(posedge hwclk);
    #1;
    chk("final_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
